// File: rtl/rob_tag_allocator_if.sv
// Dispatch / completion / retire bundle between the ROB tag allocator and its
// neighbours (decode/dispatch, CDB, map table, commit datapath).
interface rob_tag_allocator_if;
    logic        flush_in;
    logic        inst1_valid_in;
    logic [4:0]  inst1_dest_in;
    logic        inst2_valid_in;
    logic [4:0]  inst2_dest_in;
    logic [7:0]  cdb1_tag_in;
    logic [7:0]  cdb2_tag_in;
    logic [7:0]  inst1_tag_out;
    logic [7:0]  inst2_tag_out;
    logic        stall_out;
    logic        retire1_valid_out;
    logic [7:0]  retire1_tag_out;
    logic [4:0]  retire1_dest_out;
    logic        retire2_valid_out;
    logic [7:0]  retire2_tag_out;
    logic [4:0]  retire2_dest_out;
    logic [31:0] clear_entries_out;
    logic [6:0]  free_count_out;
    logic        empty_out;

    // Pipeline side: drives dispatch/completion, consumes tags and retire info.
    modport master (
        output flush_in, inst1_valid_in, inst1_dest_in, inst2_valid_in, inst2_dest_in,
               cdb1_tag_in, cdb2_tag_in,
        input  inst1_tag_out, inst2_tag_out, stall_out,
               retire1_valid_out, retire1_tag_out, retire1_dest_out,
               retire2_valid_out, retire2_tag_out, retire2_dest_out,
               clear_entries_out, free_count_out, empty_out
    );

    // Allocator side.
    modport slave (
        input  flush_in, inst1_valid_in, inst1_dest_in, inst2_valid_in, inst2_dest_in,
               cdb1_tag_in, cdb2_tag_in,
        output inst1_tag_out, inst2_tag_out, stall_out,
               retire1_valid_out, retire1_tag_out, retire1_dest_out,
               retire2_valid_out, retire2_tag_out, retire2_dest_out,
               clear_entries_out, free_count_out, empty_out
    );
endinterface

// File: rtl/rob_tag_allocator.sv
// Tag-only reorder buffer for the 2-wide OoO core: allocates up to two tags per
// cycle, marks completion from two CDBs, retires up to two entries in order and
// tells the map table which still-current mappings to clear on retire.
module rob_tag_allocator #(
    parameter int ROB_DEPTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    rob_tag_allocator_if.slave bus
);
    localparam int         IDX_W     = $clog2(ROB_DEPTH);
    localparam logic [7:0] NULL_TAG  = 8'hFF;
    localparam logic [4:0] ZERO_REG  = 5'd31;
    localparam logic [6:0] DEPTH_CNT = 7'(ROB_DEPTH);

    typedef logic [IDX_W-1:0] idx_t;

    logic [ROB_DEPTH-1:0] valid_q, done_q, sup_q;
    logic [4:0]           dest_q [ROB_DEPTH];
    idx_t                 head_q, tail_q;
    logic [6:0]           count_q;

    logic        clearing, stall, alloc1, alloc2, ret1, ret2;
    logic        cdb1_hit, cdb2_hit, sup1_new;
    idx_t        idx1, idx2, head_p1, cdb1_idx, cdb2_idx;
    logic [6:0]  free_cnt;
    logic [1:0]  n_alloc, n_ret;
    logic [31:0] clear_vec;

    // Tags carry the index in [5:0]; bits 7:6 stay 0 so the map table can
    // use bit 6 as its ready flag.
    function automatic logic [7:0] to_tag(input idx_t idx);
        return {2'b00, 6'(idx)};
    endfunction

    // Dispatch, retire, completion decode and map-table clear vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        clear_vec = '0;
        clearing  = reset | bus.flush_in;
        free_cnt  = DEPTH_CNT - count_q;
        // All-or-nothing: two free entries are required even for one request.
        stall     = clearing || (free_cnt < 7'd2);
        alloc1    = !stall && bus.inst1_valid_in;
        alloc2    = !stall && bus.inst2_valid_in;
        idx1      = tail_q;
        idx2      = bus.inst1_valid_in ? tail_q + idx_t'(1) : tail_q;
        n_alloc   = {1'b0, alloc1} + {1'b0, alloc2};
        // Slot 2 writing the same arch reg makes slot 1's mapping stale at once.
        sup1_new  = alloc2 && (bus.inst1_dest_in == bus.inst2_dest_in)
                    && (bus.inst1_dest_in != ZERO_REG);

        head_p1   = head_q + idx_t'(1);
        ret1      = !clearing && valid_q[head_q] && done_q[head_q];
        ret2      = ret1 && valid_q[head_p1] && done_q[head_p1];
        n_ret     = {1'b0, ret1} + {1'b0, ret2};

        // Any tag with bits above the index set (incl. the null tag) misses.
        cdb1_hit  = ((bus.cdb1_tag_in >> IDX_W) == 8'd0);
        cdb2_hit  = ((bus.cdb2_tag_in >> IDX_W) == 8'd0);
        cdb1_idx  = bus.cdb1_tag_in[IDX_W-1:0];
        cdb2_idx  = bus.cdb2_tag_in[IDX_W-1:0];

        // Clear only mappings nobody newer has taken over, including this cycle.
        if (ret1 && dest_q[head_q] != ZERO_REG && !sup_q[head_q]
            && !(ret2 && dest_q[head_p1] == dest_q[head_q])
            && !(alloc1 && bus.inst1_dest_in == dest_q[head_q])
            && !(alloc2 && bus.inst2_dest_in == dest_q[head_q]))
            clear_vec[dest_q[head_q]] = 1'b1;
        if (ret2 && dest_q[head_p1] != ZERO_REG && !sup_q[head_p1]
            && !(alloc1 && bus.inst1_dest_in == dest_q[head_p1])
            && !(alloc2 && bus.inst2_dest_in == dest_q[head_p1]))
            clear_vec[dest_q[head_p1]] = 1'b1;
    end

    // Pointers, occupancy and per-entry status bits.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
        if (clearing) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            sup_q   <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (valid_q[i] && alloc1 && bus.inst1_dest_in != ZERO_REG
                    && dest_q[i] == bus.inst1_dest_in)
                    sup_q[i] <= 1'b1;
                if (valid_q[i] && alloc2 && bus.inst2_dest_in != ZERO_REG
                    && dest_q[i] == bus.inst2_dest_in)
                    sup_q[i] <= 1'b1;
                if (valid_q[i] && ((cdb1_hit && cdb1_idx == idx_t'(i))
                                || (cdb2_hit && cdb2_idx == idx_t'(i))))
                    done_q[i] <= 1'b1;
            end
            if (ret1) valid_q[head_q]  <= 1'b0;
            if (ret2) valid_q[head_p1] <= 1'b0;
            // Allocated slots are always free, so these never collide with retire.
            if (alloc1) begin
                valid_q[idx1] <= 1'b1;
                done_q[idx1]  <= 1'b0;
                sup_q[idx1]   <= sup1_new;
            end
            if (alloc2) begin
                valid_q[idx2] <= 1'b1;
                done_q[idx2]  <= 1'b0;
                sup_q[idx2]   <= 1'b0;
            end
            head_q  <= head_q + idx_t'(n_ret);
            tail_q  <= tail_q + idx_t'(n_alloc);
            count_q <= count_q + 7'(n_alloc) - 7'(n_ret);
        end
    end

    // Destination register storage, written on allocation.
    always_ff @(posedge clock) begin
        // NOTE: dest storage has no reset; it is only read behind a valid bit that reset does clear.
        if (alloc1) dest_q[idx1] <= bus.inst1_dest_in;
        if (alloc2) dest_q[idx2] <= bus.inst2_dest_in;
    end

    assign bus.inst1_tag_out     = alloc1 ? to_tag(idx1) : NULL_TAG;
    assign bus.inst2_tag_out     = alloc2 ? to_tag(idx2) : NULL_TAG;
    assign bus.stall_out         = stall;
    assign bus.retire1_valid_out = ret1;
    assign bus.retire1_tag_out   = to_tag(head_q);
    assign bus.retire1_dest_out  = dest_q[head_q];
    assign bus.retire2_valid_out = ret2;
    assign bus.retire2_tag_out   = to_tag(head_p1);
    assign bus.retire2_dest_out  = dest_q[head_p1];
    assign bus.clear_entries_out = clear_vec;
    assign bus.free_count_out    = free_cnt;
    assign bus.empty_out         = (count_q == 7'd0);
endmodule

// File: tb/tb_rob_tag_allocator.sv
// Directed bench for rob_tag_allocator: a per-cycle vector table covering
// dispatch, completion, retire, supersede/clear and flush, followed by a
// hand-written fill-to-full sequence with tail wrap.
module tb_rob_tag_allocator;
    localparam logic [7:0] NT = 8'hFF;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    rob_tag_allocator_if bus ();

    rob_tag_allocator #(.ROB_DEPTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, flush, v1;
        logic [4:0]  d1;
        logic        v2;
        logic [4:0]  d2;
        logic [7:0]  c1, c2;
        logic [7:0]  t1, t2;
        logic        st;
        logic [6:0]  free;
        logic        empty;
        logic [31:0] clr;
        logic        r1v;
        logic [7:0]  r1t;
        logic [4:0]  r1d;
        logic        r2v;
        logic [7:0]  r2t;
        logic [4:0]  r2d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, flush, v1, input logic [4:0] d1, input logic v2, input logic [4:0] d2,
        input logic [7:0] c1, c2, input logic [7:0] t1, t2, input logic st,
        input logic [6:0] free, input logic empty, input logic [31:0] clr,
        input logic r1v, input logic [7:0] r1t, input logic [4:0] r1d,
        input logic r2v, input logic [7:0] r2t, input logic [4:0] r2d);
        vec_t v;
        v.rst = rst; v.flush = flush; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2;
        v.c1 = c1; v.c2 = c2; v.t1 = t1; v.t2 = t2; v.st = st; v.free = free;
        v.empty = empty; v.clr = clr; v.r1v = r1v; v.r1t = r1t; v.r1d = r1d;
        v.r2v = r2v; v.r2t = r2t; v.r2d = r2d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let them settle.
    task automatic drive(input logic rst, fl, v1, input logic [4:0] d1, input logic v2,
                         input logic [4:0] d2, input logic [7:0] c1, c2);
        @(negedge clock);
        reset              = rst;
        bus.flush_in       = fl;
        bus.inst1_valid_in = v1;
        bus.inst1_dest_in  = d1;
        bus.inst2_valid_in = v2;
        bus.inst2_dest_in  = d2;
        bus.cdb1_tag_in    = c1;
        bus.cdb2_tag_in    = c2;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, NT, NT);
        drive(1, 0, 0, 0, 0, 0, NT, NT);

        // rst fl v1 d1 v2 d2 c1 c2 | t1 t2 stall free empty clear | r1v r1t r1d r2v r2t r2d
        vecs.push_back(mk(1,0,1, 3,1, 4,NT,NT,    NT,   NT,1,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 3,1, 4,NT,NT, 8'h00,8'h01,0,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,8'h01,NT, NT,   NT,0,30,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,8'h00, NT,   NT,0,30,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,30,0,32'h18, 1,8'h00,3,1,8'h01,4));
        vecs.push_back(mk(0,0,1, 5,0, 0,NT,NT, 8'h02,   NT,0,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1, 5,NT,NT,    NT,8'h03,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,8'h02,8'h03, NT,NT,0,30,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,30,0,32'h20, 1,8'h02,5,1,8'h03,5));
        vecs.push_back(mk(0,0,1, 5,1, 5,NT,NT, 8'h04,8'h05,0,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,8'h04,8'h05, NT,NT,0,30,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 5,0, 0,NT,NT, 8'h06,   NT,0,30,0,32'h0,  1,8'h04,5,1,8'h05,5));
        vecs.push_back(mk(0,0,1,31,0, 0,8'h06,NT, 8'h07,NT,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,30,0,32'h20, 1,8'h06,5,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,8'h07,NT, NT,   NT,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,31,0,32'h0,  1,8'h07,31,0,0,0));
        vecs.push_back(mk(0,0,1, 7,0, 0,NT,NT, 8'h08,   NT,0,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,8'h48,8'h28, NT,NT,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,8'h08, NT,   NT,0,31,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,31,0,32'h80, 1,8'h08,7,0,0,0));
        vecs.push_back(mk(0,0,1, 1,1, 2,NT,NT, 8'h09,8'h0A,0,32,1,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 1,1, 2,NT,NT, 8'h0B,8'h0C,0,30,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 1,1, 2,NT,NT, 8'h0D,8'h0E,0,28,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 1,1, 2,NT,NT, 8'h0F,8'h10,0,26,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 1,1, 2,8'h09,8'h0A, 8'h11,8'h12,0,24,0,32'h0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1, 1,1, 2,NT,NT,    NT,   NT,1,22,0,32'h0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,NT,NT,    NT,   NT,0,32,1,32'h0,  0,0,0,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2,
                  vecs[i].c1, vecs[i].c2);
            check($sformatf("v%0d_tag1", i),  32'(bus.inst1_tag_out),     32'(vecs[i].t1));
            check($sformatf("v%0d_tag2", i),  32'(bus.inst2_tag_out),     32'(vecs[i].t2));
            check($sformatf("v%0d_stall", i), 32'(bus.stall_out),         32'(vecs[i].st));
            check($sformatf("v%0d_free", i),  32'(bus.free_count_out),    32'(vecs[i].free));
            check($sformatf("v%0d_empty", i), 32'(bus.empty_out),         32'(vecs[i].empty));
            check($sformatf("v%0d_clear", i), bus.clear_entries_out,      vecs[i].clr);
            check($sformatf("v%0d_r1v", i),   32'(bus.retire1_valid_out), 32'(vecs[i].r1v));
            check($sformatf("v%0d_r2v", i),   32'(bus.retire2_valid_out), 32'(vecs[i].r2v));
            if (vecs[i].r1v) begin
                check($sformatf("v%0d_r1tag", i),  32'(bus.retire1_tag_out),  32'(vecs[i].r1t));
                check($sformatf("v%0d_r1dest", i), 32'(bus.retire1_dest_out), 32'(vecs[i].r1d));
            end
            if (vecs[i].r2v) begin
                check($sformatf("v%0d_r2tag", i),  32'(bus.retire2_tag_out),  32'(vecs[i].r2t));
                check($sformatf("v%0d_r2dest", i), 32'(bus.retire2_dest_out), 32'(vecs[i].r2d));
            end
        end

        // Fill from an empty ROB (head = tail = 0): 15 pairs, entry 0 writes r9.
        for (int k = 0; k < 15; k++) begin
            drive(0, 0, 1, (k == 0) ? 5'd9 : 5'd31, 1, 5'd31, NT, NT);
            check($sformatf("fill%0d_tag1", k), 32'(bus.inst1_tag_out),  32'(2 * k));
            check($sformatf("fill%0d_tag2", k), 32'(bus.inst2_tag_out),  32'(2 * k + 1));
            check($sformatf("fill%0d_free", k), 32'(bus.free_count_out), 32'(32 - 2 * k));
        end
        drive(0, 0, 1, 31, 0, 0, NT, NT);
        check("fill31_tag1", 32'(bus.inst1_tag_out),  32'h1E);
        check("fill31_free", 32'(bus.free_count_out), 32'd2);

        // One free entry: a single-slot request is still refused.
        drive(0, 0, 1, 31, 0, 0, NT, NT);
        check("full1_stall", 32'(bus.stall_out),     32'd1);
        check("full1_tag1",  32'(bus.inst1_tag_out), 32'(NT));
        check("full1_free",  32'(bus.free_count_out), 32'd1);
        drive(0, 0, 1, 31, 0, 0, 8'h00, NT);
        check("full2_stall", 32'(bus.stall_out),         32'd1);
        check("full2_r1v",   32'(bus.retire1_valid_out), 32'd0);

        // Entry 0 retires; its freed slot is not usable until the next edge.
        drive(0, 0, 1, 31, 0, 0, NT, NT);
        check("ret0_stall", 32'(bus.stall_out),         32'd1);
        check("ret0_tag1",  32'(bus.inst1_tag_out),     32'(NT));
        check("ret0_r1v",   32'(bus.retire1_valid_out), 32'd1);
        check("ret0_r1tag", 32'(bus.retire1_tag_out),   32'h00);
        check("ret0_r2v",   32'(bus.retire2_valid_out), 32'd0);
        check("ret0_clear", bus.clear_entries_out,      32'h200);

        // Two free: allocation resumes across the 31 -> 0 wrap.
        drive(0, 0, 1, 31, 1, 31, NT, NT);
        check("wrap_stall", 32'(bus.stall_out),      32'd0);
        check("wrap_tag1",  32'(bus.inst1_tag_out),  32'h1F);
        check("wrap_tag2",  32'(bus.inst2_tag_out),  32'h00);
        check("wrap_free",  32'(bus.free_count_out), 32'd2);
        drive(0, 0, 0, 0, 0, 0, NT, NT);
        check("full_stall", 32'(bus.stall_out),      32'd1);
        check("full_free",  32'(bus.free_count_out), 32'd0);
        check("full_empty", 32'(bus.empty_out),      32'd0);

        // Reset from full.
        drive(1, 0, 1, 3, 0, 0, NT, NT);
        check("rst_stall", 32'(bus.stall_out), 32'd1);
        drive(0, 0, 0, 0, 0, 0, NT, NT);
        check("rst_free",  32'(bus.free_count_out), 32'd32);
        check("rst_empty", 32'(bus.empty_out),      32'd1);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_tag_allocator.md
Name: rob_tag_allocator

Overview:
- Tag-only reorder buffer for the 2-wide out-of-order core.
- Sits between decode/dispatch and the map table:
  - allocates ROB tags for up to 2 instructions per cycle; these drive the map table's inst1_tag_in/inst2_tag_in;
  - tracks completion from the two CDB tags;
  - retires up to 2 instructions per cycle in program order;
  - generates the map table's clear_entries vector for retired destinations that are still mapped.
- Holds no data values; the register file and commit datapath consume the retire outputs.

Parameters:
ROB_DEPTH, 32, number of entries; power of two, 4..64; entry index occupies tag bits [5:0].

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
flush_in  in  1  synchronous squash of all in-flight entries (mispredict)
inst1_valid_in  in  1  older dispatch slot requests an entry
inst1_dest_in  in  5  arch dest of slot 1; 31 = zero reg
inst2_valid_in  in  1  younger dispatch slot requests an entry
inst2_dest_in  in  5  arch dest of slot 2
cdb1_tag_in  in  8  completing tag, 8'hFF = none
cdb2_tag_in  in  8  completing tag, 8'hFF = none
inst1_tag_out  out  8  tag allocated to slot 1, 8'hFF if none
inst2_tag_out  out  8  tag allocated to slot 2, 8'hFF if none
stall_out  out  1  dispatch refused this cycle
retire1_valid_out  out  1  oldest entry retires
retire1_tag_out  out  8  its tag
retire1_dest_out  out  5  its arch dest
retire2_valid_out  out  1  second-oldest entry retires
retire2_tag_out  out  8  its tag
retire2_dest_out  out  5  its arch dest
clear_entries_out  out  32  per-arch-reg clear to map table
free_count_out  out  7  free entries (registered state)
empty_out  out  1  no valid entries

Behaviour:
- Reset: synchronous, active-high on clock; flush_in has the same effect.
  - Registered state: head=tail=0, count=0, all valid/done/superseded bits cleared.
  - Outputs in a reset or flush cycle: tags 8'hFF, stall_out=1, retire valids 0, clear_entries_out=0.
  - empty_out and free_count_out show registered state; after the clearing edge they read 1 and ROB_DEPTH.
  - Reset has priority over flush; a flush cancels any dispatch or retire presented that cycle.
- Tag format: {2'b00, idx[5:0]}.
  - Bit 7 = 0 and bit 6 = 0 always; the map table uses bit 6 as its ready flag.
  - 8'hFF is the null tag.
- Entry state: valid, done, superseded, dest[4:0].
- Dispatch is combinational in the same cycle and registers at the edge.
  - Allocation is all-or-nothing: if free_count < 2, stall_out=1, both tags are 8'hFF and nothing is allocated, even when only one slot is valid.
  - Otherwise stall_out=0:
    - slot 1 valid: gets idx tail;
    - slot 2 valid: gets the next idx, i.e. tail+1 if slot 1 valid, else tail;
    - an invalid slot outputs 8'hFF and consumes no entry.
  - tail advances by the number allocated, mod ROB_DEPTH.
  - Freed entries become visible to free_count/dispatch only after the edge; there is no same-cycle retire-to-dispatch bypass.
- Supersede: on dispatch with dest != 31, every valid entry with the same dest gets superseded=1 at the edge.
  - Slot 2 also supersedes slot 1's new entry when the dests match.
  - Entries with dest 31 are never superseded and never clear.
- Completion: a CDB tag != 8'hFF whose idx addresses a valid entry sets done at the edge.
  - Otherwise the tag is ignored, including bits [7:6] nonzero.
  - Both CDBs may hit different entries in the same cycle; the same tag on both is harmless.
- Retire is combinational from registered state.
  - retire1_valid = head valid & done.
  - retire2_valid = retire1_valid & (head+1) valid & done.
  - head advances by the number retired.
  - Minimum latency: CDB in cycle N → retire_valid in cycle N+1.
- clear_entries_out bit r is set for a retiring entry with dest r != 31 when all of the following hold:
  - superseded = 0;
  - r is not written by the second retiree;
  - r is not written by any valid dispatch this cycle.
  - All other bits are 0.
- Simultaneous dispatch, completion and retire in one cycle are all legal.
- count_next = count + allocated − retired; count never exceeds ROB_DEPTH.
- Full: count = ROB_DEPTH → stall. Empty: empty_out=1, retire valids 0.

Test Plan:
- Reset, then dispatch slot1 dest 3 and slot2 dest 4 → tags 8'h00/8'h01 same cycle; free_count 32→30 next cycle; empty_out 0.
- cdb1=8'h01 then cdb2=8'h00 → no retire after the first; cycle after the second, retire1 tag 00 dest 3 and retire2 tag 01 dest 4, clear_entries_out = 32'h18.
- Dispatch dest 5 (tag 02), later dest 5 again (tag 03), complete both → both retire, clear_entries_out = 32'h20 (bit 5 set once, from 03 only); same with a dest-5 dispatch in the retire cycle → clear_entries_out = 0.
- Fill to 31 entries, request one slot → stall_out=1, tags FF; retire one, next cycle still refused only if free <2, allocation resumes at 2 free with tail wrap 31→0 (tag 8'h1F then 8'h00).
- Dest 31 dispatch, complete, retire → retire valid, clear_entries_out = 0.
- Flush with 10 entries valid plus pending dispatch → that cycle tags FF, no retire; next cycle empty_out=1, free_count 32, next allocation tag 8'h00.
